uart_rx_os: RTL and testbench
=============================

Name: uart_rx_os

Overview:
Parametrised oversampling UART receiver, successor to the fixed 9600-baud receiver.
- Run-time baud divisor, configurable oversample rate and data width.
- Optional parity; 3-sample majority vote per bit; false-start rejection.
- Framing, parity and overrun error reporting; valid/ready output handshake.
- Sits between the board serial pin and the core's byte-wide command/data path.

Parameters:
- DATA_BITS, 8: data bits per frame, legal 5..9, LSB first.
- OS_RATE, 16: oversample ticks per bit, even, legal 8..32.
- DIV_W, 16: width of baud_div.
- PARITY_EN, 0: 1 means one parity bit follows the data bits.
- PARITY_ODD, 0: 0 selects even parity, 1 selects odd parity. Ignored when PARITY_EN=0.

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- serial_in, input, 1: asynchronous line input, idle high.
- baud_div, input, DIV_W: clocks per oversample tick minus 1.
- data_out, output, DATA_BITS: received word.
- data_valid, output, 1: data_out holds an unread word.
- data_ready, input, 1: consumer accepts the word.
- frame_err, output, 1: stop-bit error flag for the word on data_out.
- parity_err, output, 1: parity error flag for the word on data_out.
- overrun, output, 1: one-clock pulse when a completed frame is dropped.
- busy, output, 1: high whenever state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - 2-flop synchronizer set to 1.
  - State = IDLE; all counters = 0.
  - data_out = 0; data_valid, frame_err, parity_err, overrun, busy = 0.
- Synchronizer: serial_in passes through 2 flops. Only the second flop (rx_s) is used.
- Tick generator:
  - div_cnt counts 0..div_lat, where div_lat is baud_div captured on the start edge.
  - tick = 1 for one clock when div_cnt == div_lat; div_cnt then returns to 0.
  - Changes to baud_div mid-frame are ignored.
- Bit timing: os_cnt counts ticks 0..OS_RATE-1 within each bit. It wraps to 0 and advances the bit phase.
- Majority vote:
  - rx_s is sampled on the ticks where os_cnt = M-1, M, M+1, with M = OS_RATE/2.
  - Bit value = majority of the 3 samples, decided on the M+1 tick.
- States:
  - IDLE: on rx_s == 0, zero div_cnt and os_cnt, latch baud_div, go to START.
  - START: at the vote, a result of 1 is a false start → IDLE with no outputs. A result of 0 → DATA at the next bit boundary.
  - DATA: shift voted bits LSB first. After DATA_BITS bits → PARITY if PARITY_EN, else → STOP.
  - PARITY: compare the voted bit with the computed parity; keep the result internally.
  - STOP: at the vote, complete the frame and go to IDLE immediately (mid stop bit). This allows back-to-back frames.
- Frame completion (clock after the stop vote):
  - If data_valid == 0 or data_ready == 1 in that clock:
    - Load data_out.
    - frame_err = (stop vote == 0).
    - parity_err = parity mismatch (0 when PARITY_EN=0).
    - data_valid = 1.
  - Otherwise the frame is discarded and overrun pulses for 1 clock. Existing outputs are unchanged.
- Handshake:
  - data_valid && data_ready clears data_valid the next clock, unless a frame completes in the same clock.
  - data_out, frame_err and parity_err remain stable while data_valid = 1.
- Latency: data_valid rises exactly 1 clk after the stop-bit M+1 tick.
- A frame with frame_err is still delivered. Break detection is out of scope.
- Reset mid-frame aborts the frame with no output. After release, the receiver waits in IDLE for the next falling edge.
- baud_div = 0 is legal: tick every clock.

Test Plan:
- Nominal frame:
  - Setup: OS_RATE=16, baud_div=11 (192 clk/bit), data_ready=1.
  - Stimulus: send 0xA5 with 1 stop bit.
  - Required: data_out=0xA5 and data_valid high for exactly 1 clk, 1 clk after the stop vote; frame_err=0; parity_err=0.
- Glitches:
  - Stimulus: a 40-clk low glitch on idle line → required: busy rises, returns to IDLE at the start vote, data_valid never asserts.
  - Stimulus: one 12-clk low glitch at the centre of data bit 3 of 0xFF → required: data_out=0xFF (majority vote suppresses it).
- Framing error:
  - Stimulus: send 0x3C with stop bit forced low.
  - Required: data_out=0x3C, frame_err=1 with data_valid. The next frame 0x01 is received correctly with frame_err=0.
- Parity:
  - Setup: PARITY_EN=1, PARITY_ODD=0.
  - Stimulus: 0x07 with parity bit 1 → required: parity_err=0. Stimulus: 0x07 with parity bit 0 → required: parity_err=1.
- Overrun and reset:
  - Setup: data_ready=0.
  - Stimulus: send 0x11 then 0x22 back-to-back.
  - Required: data_out stays 0x11 and overrun pulses 1 clk. After data_ready=1, data_valid drops.
  - Stimulus: assert rst_n=0 mid data bit 4 → required: all outputs 0 immediately, and the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with majority vote, false-start rejection and error flags.
// data_valid rises 1 clk after the stop-bit vote; a frame completing while the held word is unread is dropped (overrun pulse).
module uart_rx_os #(
  parameter int DATA_BITS  = 8,
  parameter int OS_RATE    = 16,
  parameter int DIV_W      = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 serial_in,
  input  logic [DIV_W-1:0]     baud_div,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int OS_W = $clog2(OS_RATE);
  localparam int BC_W = $clog2(DATA_BITS + 1);
  localparam int M    = OS_RATE / 2;
  localparam logic [OS_W-1:0] OS_M_LO = OS_W'(M - 1);
  localparam logic [OS_W-1:0] OS_M    = OS_W'(M);
  localparam logic [OS_W-1:0] OS_M_HI = OS_W'(M + 1);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OS_RATE - 1);
  localparam logic [BC_W-1:0] BC_FULL = BC_W'(DATA_BITS);
  localparam logic            ODD     = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state, state_nxt;
  logic                 sync1, rx_s;
  logic [DIV_W-1:0]     div_cnt, div_lat;
  logic [OS_W-1:0]      os_cnt;
  logic [BC_W-1:0]      bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 samp_a, samp_b, par_bad;
  logic                 tick, at_vote, bit_end, vote, done;

  assign tick    = (div_cnt == div_lat);
  assign at_vote = tick && (os_cnt == OS_M_HI);
  assign bit_end = tick && (os_cnt == OS_LAST);
  // Third sample is rx_s itself, so the vote resolves on the M+1 tick.
  assign vote    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    case (state)
      IDLE:   if (!rx_s) state_nxt = START;
      START: begin
        if (at_vote && vote) state_nxt = IDLE;
        else if (bit_end)    state_nxt = DATA;
      end
      DATA:   if (bit_end && bit_cnt == BC_FULL) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_nxt = STOP;
      STOP: begin
        if (at_vote) begin
          state_nxt = IDLE;
          done      = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sync1      <= 1'b1;
      rx_s       <= 1'b1;
      div_cnt    <= '0;
      div_lat    <= '0;
      os_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      samp_a     <= 1'b0;
      samp_b     <= 1'b0;
      par_bad    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync1   <= serial_in;
      rx_s    <= sync1;
      state   <= state_nxt;
      overrun <= 1'b0;

      if (state == IDLE) begin
        div_cnt <= '0;
        os_cnt  <= '0;
        bit_cnt <= '0;
        par_bad <= 1'b0;
        if (!rx_s) div_lat <= baud_div;
      end else if (tick) begin
        div_cnt <= '0;
        os_cnt  <= (os_cnt == OS_LAST) ? '0 : os_cnt + 1'b1;
        if (os_cnt == OS_M_LO) samp_a <= rx_s;
        if (os_cnt == OS_M)    samp_b <= rx_s;
        if (at_vote && state == DATA) begin
          shreg   <= {vote, shreg[DATA_BITS-1:1]};
          bit_cnt <= bit_cnt + 1'b1;
        end
        if (at_vote && state == PARITY) par_bad <= (vote != ((^shreg) ^ ODD));
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      // A finishing frame takes priority over clearing a consumed word.
      if (done) begin
        if (!data_valid || data_ready) begin
          data_out   <= shreg;
          frame_err  <= ~vote;
          parity_err <= par_bad;
          data_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Randomised + directed bench for uart_rx_os: a plain-parity and an even-parity instance, frame-level reference model and scoreboard.
module tb_uart_rx_os;

  localparam int OS = 16;
  localparam int M  = OS / 2;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    logic       pe;
    longint     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baud_div;
  logic        ser [2];
  logic        rdy [2];
  logic [7:0]  dout [2];
  logic        dv [2], fe [2], pe [2], ovr [2], bsy [2];

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   ovr_cnt [2];
  int   vhigh [2];
  bit   pv [2], pacc [2];
  exp_t q0 [$];
  exp_t q1 [$];

  uart_rx_os #(.DATA_BITS(8), .OS_RATE(OS), .DIV_W(16), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .serial_in(ser[0]), .baud_div(baud_div),
    .data_out(dout[0]), .data_valid(dv[0]), .data_ready(rdy[0]),
    .frame_err(fe[0]), .parity_err(pe[0]), .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_os #(.DATA_BITS(8), .OS_RATE(OS), .DIV_W(16), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .serial_in(ser[1]), .baud_div(baud_div),
    .data_out(dout[1]), .data_valid(dv[1]), .data_ready(rdy[1]),
    .frame_err(fe[1]), .parity_err(pe[1]), .overrun(ovr[1]), .busy(bsy[1]));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard: a word is presented when data_valid rises or is refilled right after an accept.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   have;
    for (int i = 0; i < 2; i++) begin
      if (rst_n) begin
        if (ovr[i]) ovr_cnt[i]++;
        if (dv[i]) vhigh[i]++;
        if (dv[i] && (!pv[i] || pacc[i])) begin
          have = 1'b0;
          if (i == 0) begin
            if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          end else begin
            if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          end
          if (!have) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_word dut%0d: got data=%h, required no word", i, dout[i]);
          end else begin
            chk($sformatf("data dut%0d", i), dout[i], e.d);
            chk($sformatf("frame_err dut%0d", i), fe[i], e.fe);
            chk($sformatf("parity_err dut%0d", i), pe[i], e.pe);
            chk($sformatf("latency_cycle dut%0d", i), cyc, e.cyc);
          end
        end
      end
      pv[i]   = dv[i];
      pacc[i] = dv[i] && rdy[i];
    end
  end

  task automatic hold(input int sel, input logic v, input int n);
    ser[sel] = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame; the expected word is derived from the frame contents and bit timing alone.
  task automatic send(input int sel, input logic [7:0] d, input logic stop_b, input logic par_b,
                      input bit expect_it, input int glitch_bit, input int abort_bit,
                      input int idle_bits, input bit mess_div);
    int          dd, bt, nb, first;
    logic        v;
    logic [15:0] saved;
    exp_t        e;
    saved = baud_div;
    dd    = int'(baud_div) + 1;
    bt    = OS * dd;
    nb    = (sel == 1) ? 10 : 9;
    @(posedge clk);
    #1;
    e.d   = d;
    e.fe  = ~stop_b;
    e.pe  = (sel == 1) ? (par_b != (^d)) : 1'b0;
    e.cyc = longint'(cyc) + 3 + longint'(nb * OS + M + 2) * dd;
    if (expect_it && abort_bit < 0) begin
      if (sel == 0) q0.push_back(e);
      else          q1.push_back(e);
    end
    for (int b = 0; b <= nb; b++) begin
      if (b == 0)       v = 1'b0;
      else if (b <= 8)  v = d[b-1];
      else if (b == nb) v = stop_b;
      else              v = par_b;
      if (b == nb && mess_div) baud_div = saved;
      if (b >= 1 && b <= 8 && b - 1 == abort_bit) begin
        hold(sel, v, bt / 2);
        return;
      end
      if (b >= 1 && b <= 8 && b - 1 == glitch_bit) begin
        first = M * dd - dd / 2;
        hold(sel, v, first);
        hold(sel, ~v, dd);
        hold(sel, v, bt - first - dd);
      end else begin
        hold(sel, v, bt);
      end
      if (b == 2 && mess_div) baud_div = 16'($urandom_range(0, 20));
    end
    hold(sel, 1'b1, idle_bits * bt);
  endtask

  initial begin : stim
    int   c0, base;
    logic [7:0] rd;
    int   sel;
    baud_div = 16'd11;
    ser[0] = 1'b1; ser[1] = 1'b1;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    ovr_cnt[0] = 0; ovr_cnt[1] = 0;
    vhigh[0] = 0; vhigh[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset data_out dut%0d", i), dout[i], 0);
      chk($sformatf("reset data_valid dut%0d", i), dv[i], 0);
      chk($sformatf("reset frame_err dut%0d", i), fe[i], 0);
      chk($sformatf("reset parity_err dut%0d", i), pe[i], 0);
      chk($sformatf("reset overrun dut%0d", i), ovr[i], 0);
      chk($sformatf("reset busy dut%0d", i), bsy[i], 0);
    end
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Nominal frame; valid must be a single-clock pulse with data_ready held high.
    base = vhigh[0];
    send(0, 8'hA5, 1'b1, 1'b0, 1'b1, -1, -1, 2, 1'b0);
    chk("valid_pulse_width", vhigh[0] - base, 1);

    // False start: 40-clk low glitch on an idle line.
    @(posedge clk);
    #1;
    c0 = cyc;
    hold(0, 1'b0, 40);
    ser[0] = 1'b1;
    chk("false_start busy_during", bsy[0], 1);
    wait_cyc(c0 + 3 + (M + 2) * 12 - 2);
    chk("false_start busy_before_vote", bsy[0], 1);
    wait_cyc(c0 + 3 + (M + 2) * 12 + 1);
    chk("false_start busy_after_vote", bsy[0], 0);
    hold(0, 1'b1, 2 * OS * 12);

    // Single-sample glitch inside data bit 3 is outvoted.
    send(0, 8'hFF, 1'b1, 1'b0, 1'b1, 3, -1, 2, 1'b0);

    // Framing error, then a clean frame.
    send(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1, -1, 2, 1'b0);
    send(0, 8'h01, 1'b1, 1'b0, 1'b1, -1, -1, 2, 1'b0);

    // Even parity instance: correct and wrong parity bit.
    send(1, 8'h07, 1'b1, 1'b1, 1'b1, -1, -1, 2, 1'b0);
    send(1, 8'h07, 1'b1, 1'b0, 1'b1, -1, -1, 2, 1'b0);

    // Overrun: second frame dropped while the first is unread.
    rdy[0] = 1'b0;
    base = ovr_cnt[0];
    send(0, 8'h11, 1'b1, 1'b0, 1'b1, -1, -1, 0, 1'b0);
    send(0, 8'h22, 1'b1, 1'b0, 1'b0, -1, -1, 1, 1'b0);
    chk("overrun_pulses", ovr_cnt[0] - base, 1);
    chk("overrun held data", dout[0], 8'h11);
    chk("overrun held valid", dv[0], 1);
    rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("valid_drops_after_ready", dv[0], 0);

    // Reset in the middle of data bit 4.
    rd = 8'($urandom);
    send(0, rd, 1'b1, 1'b0, 1'b1, -1, 4, 0, 1'b0);
    ser[0] = 1'b1;
    rst_n  = 1'b0;
    #1;
    chk("midreset data_out", dout[0], 0);
    chk("midreset data_valid", dv[0], 0);
    chk("midreset frame_err", fe[0], 0);
    chk("midreset busy", bsy[0], 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send(0, 8'h5A, 1'b1, 1'b0, 1'b1, -1, -1, 2, 1'b0);

    // Random frames over both instances at fast and zero divisors.
    for (int k = 0; k < 14; k++) begin
      baud_div = 16'($urandom_range(0, 3));
      sel = int'($urandom_range(0, 1));
      rd  = 8'($urandom);
      send(sel, rd, ($urandom_range(0, 3) != 0), 1'($urandom), 1'b1, -1, -1,
           2, ($urandom_range(0, 2) == 0));
    end

    repeat (50) @(posedge clk);
    #1;
    chk("queue0 drained", q0.size(), 0);
    chk("queue1 drained", q1.size(), 0);
    chk("total overruns dut0", ovr_cnt[0], 1);
    chk("total overruns dut1", ovr_cnt[1], 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
